usb_sie_phase_ctrl: RTL and testbench

- Link-level sequencer between the protocol engine (PE) and the USB SIE, clocked on clk12_i.
- Owns isSendingPhase_o, which steers the shared CRC and bit-stuffing datapath and resets the RX DPPL on the TX→RX edge.
- Gates PE transmit requests into the turnaround window after a good received packet.
- Enforces the response and reply bit-time timeouts.
- Handles USB bus-reset acknowledgement.

---
 rtl/sie_defs_pkg.sv | 28 ++
 rtl/usb_bit_timer.sv | 39 +++
 rtl/usb_sie_phase_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_usb_sie_phase_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sie_defs_pkg.sv
// Shared definitions for the SIE link-level sequencer: phase states and full-speed timeouts.
// No logic of its own; constants and a constant helper only.
// Not applicable (no handshake).
package sie_defs_pkg;

    // Link phase of the SIE; 3 bits, six states used.
    typedef enum logic [2:0] {
        PH_LISTEN     = 3'd0,
        PH_TURNAROUND = 3'd1,
        PH_TX_SETUP   = 3'd2,
        PH_TX_ACTIVE  = 3'd3,
        PH_WAIT_REPLY = 3'd4,
        PH_BUS_RESET  = 3'd5
    } sie_phase_state_t;

    // Full-speed turnaround limits, in 12 MHz cycles.
    localparam int USB_FS_RESP_TIMEOUT    = 16;
    localparam int USB_FS_REPLY_TIMEOUT   = 18;
    localparam int USB_FS_TX_SETUP_CYCLES = 2;

    // Bus-reset acknowledge is repeated with this period while the reset persists.
    localparam int BUS_RESET_ACK_PERIOD   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Saturating bit-time counter with synchronous clear and an equality hit against a compare value.
// Hit is combinational from the count register; count updates one cycle after clear/enable.
// No backpressure; the counter sticks at all-ones instead of wrapping.
module usb_bit_timer #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] cmp_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over counting; a full counter holds its value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = en_i & (cnt_q == cmp_i);

endmodule

// File: rtl/usb_sie_phase_ctrl.sv
// Link sequencer between PE and SIE: owns TX/RX direction, gates PE TX into the turnaround window.
// Every output is registered: events sampled on one clk12 edge are visible after that edge.
// PE requests outside the turnaround window are dropped with a reject pulse, never queued.
module usb_sie_phase_ctrl
    import sie_defs_pkg::*;
#(
    parameter int RESP_TIMEOUT    = USB_FS_RESP_TIMEOUT,
    parameter int REPLY_TIMEOUT   = USB_FS_REPLY_TIMEOUT,
    parameter int TX_SETUP_CYCLES = USB_FS_TX_SETUP_CYCLES
) (
    input  logic clk12_i,
    input  logic rstn_i,
    input  logic usbResetDetected_i,
    output logic ackUsbResetDetect_o,
    output logic busReset_o,
    input  logic rxDataValid_i,
    input  logic rxAcceptNewData_i,
    input  logic rxIsLastByte_i,
    input  logic keepPacket_i,
    input  logic rxDPPLGotSignal_i,
    output logic rxPacketOk_o,
    output logic rxPacketErr_o,
    input  logic peTxReq_i,
    input  logic peExpectReply_i,
    output logic txReqSendPacket_o,
    input  logic txDoneSending_i,
    output logic isSendingPhase_o,
    output logic txReqReject_o,
    output logic respTimeout_o,
    output logic replyTimeout_o,
    output logic txDone_o
);

    // The timer also paces the bus-reset acknowledge, so it must reach that period too.
    localparam int TMR_MAX = max_int(max_int(RESP_TIMEOUT, REPLY_TIMEOUT), BUS_RESET_ACK_PERIOD);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RESP_LAST  = TMR_W'(RESP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] REPLY_LAST = TMR_W'(REPLY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(TX_SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] ACK_LAST   = TMR_W'(BUS_RESET_ACK_PERIOD - 1);

    sie_phase_state_t state_q, state_d;
    logic             expect_q, expect_d;
    logic             dppl_q;

    logic             lb;
    logic             dppl_rise;
    logic             restart;
    logic             ack_rearm;
    logic             tmr_clr;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_cmp;
    logic             tmr_hit;

    logic ack_d,       ack_q;
    logic bus_rst_d,   bus_rst_q;
    logic rx_ok_d,     rx_ok_q;
    logic rx_err_d,    rx_err_q;
    logic tx_req_d,    tx_req_q;
    logic sending_d,   sending_q;
    logic tx_rej_d,    tx_rej_q;
    logic resp_to_d,   resp_to_q;
    logic reply_to_d,  reply_to_q;
    logic tx_done_d,   tx_done_q;

    assign lb        = rxDataValid_i & rxAcceptNewData_i & rxIsLastByte_i;
    assign dppl_rise = rxDPPLGotSignal_i & ~dppl_q;

    // Timer limit depends on which phase is being timed; it idles in LISTEN and TX_ACTIVE.
    always_comb begin
        tmr_cmp = '1;
        tmr_en  = 1'b1;
        case (state_q)
            PH_TURNAROUND: tmr_cmp = RESP_LAST;
            PH_TX_SETUP:   tmr_cmp = SETUP_LAST;
            PH_WAIT_REPLY: tmr_cmp = REPLY_LAST;
            PH_BUS_RESET:  tmr_cmp = ACK_LAST;
            default:       tmr_en  = 1'b0;
        endcase
    end

    // Restart on every phase change, on a new good packet inside the window, and per ack period.
    assign ack_rearm = (state_q == PH_BUS_RESET) & usbResetDetected_i & tmr_hit;
    assign tmr_clr   = (state_d != state_q) | restart | ack_rearm;

    usb_bit_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i  (clk12_i),
        .rstn_i (rstn_i),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .cmp_i  (tmr_cmp),
        .hit_o  (tmr_hit)
    );

    // State, expect-reply flag and DPPL history registers.
    always_ff @(posedge clk12_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= PH_LISTEN;
            expect_q <= 1'b0;
            dppl_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            dppl_q   <= rxDPPLGotSignal_i;
        end
    end

    // Next phase: bus reset overrides everything, then PE request, packet end, line activity, timeout.
    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        restart  = 1'b0;
        if (usbResetDetected_i) begin
            state_d  = PH_BUS_RESET;
            expect_d = 1'b0;
        end else begin
            case (state_q)
                PH_LISTEN: begin
                    if (lb && keepPacket_i) state_d = PH_TURNAROUND;
                end
                PH_TURNAROUND: begin
                    if (peTxReq_i) begin
                        state_d  = PH_TX_SETUP;
                        expect_d = peExpectReply_i;
                    end else if (lb) begin
                        state_d = keepPacket_i ? PH_TURNAROUND : PH_LISTEN;
                        restart = keepPacket_i;
                    end else if (dppl_rise || tmr_hit) begin
                        state_d = PH_LISTEN;
                    end
                end
                PH_TX_SETUP: begin
                    if (tmr_hit) state_d = PH_TX_ACTIVE;
                end
                PH_TX_ACTIVE: begin
                    if (txDoneSending_i) state_d = expect_q ? PH_WAIT_REPLY : PH_LISTEN;
                end
                PH_WAIT_REPLY: begin
                    if (dppl_rise || tmr_hit) state_d = PH_LISTEN;
                end
                PH_BUS_RESET: state_d = PH_LISTEN;
                default:      state_d = PH_LISTEN;
            endcase
        end
    end

    // Output next-values: pulses from this cycle's events, levels from the phase being entered.
    always_comb begin
        ack_d      = 1'b0;
        bus_rst_d  = 1'b0;
        rx_ok_d    = 1'b0;
        rx_err_d   = 1'b0;
        tx_rej_d   = 1'b0;
        resp_to_d  = 1'b0;
        reply_to_d = 1'b0;
        tx_done_d  = 1'b0;
        sending_d  = (state_d == PH_TX_SETUP) || (state_d == PH_TX_ACTIVE);
        tx_req_d   = (state_d == PH_TX_ACTIVE);
        if (usbResetDetected_i) begin
            bus_rst_d = (state_q != PH_BUS_RESET);
            ack_d     = (state_q != PH_BUS_RESET) | tmr_hit;
        end else begin
            if ((state_q == PH_LISTEN) || (state_q == PH_TURNAROUND)) begin
                rx_ok_d  = lb & keepPacket_i;
                rx_err_d = lb & ~keepPacket_i;
            end
            tx_rej_d   = peTxReq_i & (state_q != PH_TURNAROUND) & (state_q != PH_BUS_RESET);
            resp_to_d  = (state_q == PH_TURNAROUND) & tmr_hit & ~peTxReq_i & ~lb & ~dppl_rise;
            reply_to_d = (state_q == PH_WAIT_REPLY) & tmr_hit & ~dppl_rise;
            tx_done_d  = (state_q == PH_TX_ACTIVE) & txDoneSending_i;
        end
    end

    // Output registers.
    always_ff @(posedge clk12_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q      <= 1'b0;
            bus_rst_q  <= 1'b0;
            rx_ok_q    <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_req_q   <= 1'b0;
            sending_q  <= 1'b0;
            tx_rej_q   <= 1'b0;
            resp_to_q  <= 1'b0;
            reply_to_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            bus_rst_q  <= bus_rst_d;
            rx_ok_q    <= rx_ok_d;
            rx_err_q   <= rx_err_d;
            tx_req_q   <= tx_req_d;
            sending_q  <= sending_d;
            tx_rej_q   <= tx_rej_d;
            resp_to_q  <= resp_to_d;
            reply_to_q <= reply_to_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign ackUsbResetDetect_o = ack_q;
    assign busReset_o          = bus_rst_q;
    assign rxPacketOk_o        = rx_ok_q;
    assign rxPacketErr_o       = rx_err_q;
    assign txReqSendPacket_o   = tx_req_q;
    assign isSendingPhase_o    = sending_q;
    assign txReqReject_o       = tx_rej_q;
    assign respTimeout_o       = resp_to_q;
    assign replyTimeout_o      = reply_to_q;
    assign txDone_o            = tx_done_q;

endmodule

// File: tb/tb_usb_sie_phase_ctrl.sv
// Self-checking bench for usb_sie_phase_ctrl: randomized directed scenarios against event-time expectations.
// Outputs sampled 1 time unit after each rising edge; inputs changed at the same point.
// No backpressure on the bench side.
module tb_usb_sie_phase_ctrl;

    logic clk12;
    logic rstn;
    logic usbResetDetected_i, rxDataValid_i, rxAcceptNewData_i, rxIsLastByte_i, keepPacket_i;
    logic rxDPPLGotSignal_i, peTxReq_i, peExpectReply_i, txDoneSending_i;
    logic ackUsbResetDetect_o, busReset_o, rxPacketOk_o, rxPacketErr_o, txReqSendPacket_o;
    logic isSendingPhase_o, txReqReject_o, respTimeout_o, replyTimeout_o, txDone_o;

    logic [9:0] outv;
    assign outv = {ackUsbResetDetect_o, busReset_o, rxPacketOk_o, rxPacketErr_o, txReqSendPacket_o,
                   isSendingPhase_o, txReqReject_o, respTimeout_o, replyTimeout_o, txDone_o};

    localparam logic [9:0] M_ACK   = 10'b10_0000_0000;
    localparam logic [9:0] M_BRST  = 10'b01_0000_0000;
    localparam logic [9:0] M_OK    = 10'b00_1000_0000;
    localparam logic [9:0] M_ERR   = 10'b00_0100_0000;
    localparam logic [9:0] M_TXR   = 10'b00_0010_0000;
    localparam logic [9:0] M_ISS   = 10'b00_0001_0000;
    localparam logic [9:0] M_REJ   = 10'b00_0000_1000;
    localparam logic [9:0] M_RESP  = 10'b00_0000_0100;
    localparam logic [9:0] M_REPLY = 10'b00_0000_0010;
    localparam logic [9:0] M_DONE  = 10'b00_0000_0001;

    // Reference timing derived from the protocol rules (cycles).
    localparam int RESP_T  = 16;
    localparam int REPLY_T = 18;
    localparam int SETUP_T = 2;
    localparam int ACK_PER = 8;

    int n_assert = 0;
    int n_fail   = 0;

    usb_sie_phase_ctrl dut (
        .clk12_i             (clk12),
        .rstn_i              (rstn),
        .usbResetDetected_i  (usbResetDetected_i),
        .ackUsbResetDetect_o (ackUsbResetDetect_o),
        .busReset_o          (busReset_o),
        .rxDataValid_i       (rxDataValid_i),
        .rxAcceptNewData_i   (rxAcceptNewData_i),
        .rxIsLastByte_i      (rxIsLastByte_i),
        .keepPacket_i        (keepPacket_i),
        .rxDPPLGotSignal_i   (rxDPPLGotSignal_i),
        .rxPacketOk_o        (rxPacketOk_o),
        .rxPacketErr_o       (rxPacketErr_o),
        .peTxReq_i           (peTxReq_i),
        .peExpectReply_i     (peExpectReply_i),
        .txReqSendPacket_o   (txReqSendPacket_o),
        .txDoneSending_i     (txDoneSending_i),
        .isSendingPhase_o    (isSendingPhase_o),
        .txReqReject_o       (txReqReject_o),
        .respTimeout_o       (respTimeout_o),
        .replyTimeout_o      (replyTimeout_o),
        .txDone_o            (txDone_o)
    );

    initial begin
        clk12 = 1'b0;
        forever #5 clk12 = ~clk12;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk12);
        #1;
    endtask

    task automatic chk(input string tag, input int r, input logic [9:0] exp);
        n_assert++;
        assert (outv === exp) else begin
            n_fail++;
            $error("FAIL %s r=%0d observed=%b expected=%b", tag, r, outv, exp);
        end
    endtask

    // Idle inputs with harmless noise: no last-byte, so never a packet end.
    task automatic drive_idle();
        rxDataValid_i      = 1'($urandom);
        rxAcceptNewData_i  = 1'($urandom);
        rxIsLastByte_i     = 1'b0;
        keepPacket_i       = 1'($urandom);
        rxDPPLGotSignal_i  = 1'b0;
        peTxReq_i          = 1'b0;
        peExpectReply_i    = 1'($urandom);
        txDoneSending_i    = 1'b0;
        usbResetDetected_i = 1'b0;
    endtask

    task automatic drive_lb(input bit keep);
        rxDataValid_i     = 1'b1;
        rxAcceptNewData_i = 1'b1;
        rxIsLastByte_i    = 1'b1;
        keepPacket_i      = keep;
    endtask

    // Good packet, no PE request: ok pulse, then response timeout RESP_T cycles after window entry.
    task automatic resp_only(input int lead);
        for (int i = 0; i < lead; i++) begin
            drive_idle();
            tick();
            chk("lead_idle", -i, '0);
        end
        drive_idle();
        drive_lb(1'b1);
        for (int r = 1; r <= RESP_T + 4; r++) begin
            logic [9:0] e;
            tick();
            e = '0;
            if (r == 1)          e |= M_OK;
            if (r == 1 + RESP_T) e |= M_RESP;
            chk("resp_only", r, e);
            drive_idle();
        end
    endtask

    // Good packet, PE request at window cycle k, TX of L+1 active cycles, optional host activity at reply cycle m.
    task automatic txn(input int k, input int len, input bit exp_reply, input int m);
        int s, d, rend;
        s    = 2 + k;
        d    = s + SETUP_T + len;
        rend = d + REPLY_T + 4;
        drive_idle();
        drive_lb(1'b1);
        for (int r = 1; r <= rend; r++) begin
            logic [9:0] e;
            tick();
            e = '0;
            if (r == 1)                                  e |= M_OK;
            if (r >= s && r <= d)                        e |= M_ISS;
            if (r >= s + SETUP_T && r <= d)              e |= M_TXR;
            if (r == s + SETUP_T + 1)                    e |= M_REJ;
            if (r == d + 1)                              e |= M_DONE;
            if (exp_reply && m < 0 && r == d + 1 + REPLY_T) e |= M_REPLY;
            if (exp_reply && m >= 0 && r == d + m + 4)   e |= M_ERR;
            chk("txn", r, e);
            drive_idle();
            if (r == 1 + k) begin
                peTxReq_i       = 1'b1;
                peExpectReply_i = exp_reply;
            end
            if (r == s + SETUP_T) peTxReq_i = 1'b1;
            if (r == d) txDoneSending_i = 1'b1;
            if (m >= 0 && (r == d + 1 + m || r == d + 2 + m)) rxDPPLGotSignal_i = 1'b1;
            if (exp_reply && m >= 0 && r == d + m + 3) drive_lb(1'b0);
        end
    endtask

    // Bus reset arriving mid-TX, held 20 cycles, then a packet right after release.
    task automatic bus_reset_mid_tx();
        int b;
        b = 6;
        drive_idle();
        drive_lb(1'b1);
        for (int r = 1; r <= 45; r++) begin
            logic [9:0] e;
            tick();
            e = '0;
            if (r == 1 || r == 27)                               e |= M_OK;
            if (r >= 2 && r <= 5)                                e |= M_ISS;
            if (r >= 4 && r <= 5)                                e |= M_TXR;
            if (r == b)                                          e |= M_BRST;
            if (r == b || r == b + ACK_PER || r == b + 2 * ACK_PER) e |= M_ACK;
            if (r == 27 + RESP_T)                                e |= M_RESP;
            chk("bus_reset", r, e);
            drive_idle();
            if (r == 1) begin
                peTxReq_i       = 1'b1;
                peExpectReply_i = 1'b1;
            end
            if (r >= 5 && r <= 24) usbResetDetected_i = 1'b1;
            if (r == 26) drive_lb(1'b1);
        end
    endtask

    initial begin
        rstn = 1'b0;
        drive_idle();
        tick();
        chk("reset_state", 0, '0);
        tick();
        chk("reset_held", 0, '0);
        rstn = 1'b1;
        tick();
        chk("post_reset", 0, '0);

        // Response timeout with random lead-in.
        resp_only($urandom_range(0, 3));
        resp_only($urandom_range(0, 3));

        // Turnaround transactions: nominal, host reply, window boundaries, then random.
        txn(3, 1, 1'b1, -1);
        txn(3, 1, 1'b1, 10);
        txn(15, $urandom_range(0, 4), 1'b1, -1);
        txn(0, $urandom_range(0, 4), 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            int m;
            m = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 14)) : -1;
            txn($urandom_range(0, 15), $urandom_range(0, 4), 1'($urandom), m);
        end

        // Bad packet, then a PE request outside any window.
        drive_idle();
        drive_lb(1'b0);
        tick();
        chk("bad_pkt_err", 1, M_ERR);
        drive_idle();
        peTxReq_i = 1'b1;
        tick();
        chk("bad_pkt_reject", 2, M_REJ);
        drive_idle();
        for (int r = 3; r <= 6; r++) begin
            tick();
            chk("bad_pkt_quiet", r, '0);
        end

        bus_reset_mid_tx();

        // Asynchronous reset while the ok pulse is up in the turnaround window.
        drive_idle();
        drive_lb(1'b1);
        tick();
        chk("pre_async_ok", 1, M_OK);
        drive_idle();
        #3;
        rstn = 1'b0;
        #1;
        chk("async_rst_now", 1, '0);
        tick();
        chk("async_rst_held", 2, '0);
        rstn = 1'b1;
        tick();
        chk("async_rst_release", 3, '0);
        resp_only(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
